// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, repeat_cnt times,
// with an optional idle gap between repetitions and a start/busy/done handshake.
// Every output is a register loaded from the next-state decode, so all outputs
// are clean Moore functions of state and counters.
module seq_pattern_tx #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10110,
    parameter int                 GAP     = 0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int               IDX_W    = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);
    // Gap counter counts down to zero, so it is loaded with GAP-1.
    localparam logic [7:0]       GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   rep_left, rep_n;
    logic [IDX_W-1:0]   bit_idx, idx_n;
    logic [7:0]         gap_cnt, gap_n;

    // Next-state and counter update; abort outranks the last-bit decision.
    always_comb begin
        state_n = state;
        rep_n   = rep_left;
        idx_n   = bit_idx;
        gap_n   = gap_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (repeat_cnt != '0) begin
                        rep_n   = repeat_cnt;
                        idx_n   = IDX_LAST;
                        state_n = S_SEND;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (bit_idx == '0) begin
                    rep_n = rep_left - 1'b1;
                    if (rep_left > CNT_W'(1)) begin
                        idx_n = IDX_LAST;
                        if (GAP > 0) begin
                            gap_n   = GAP_LAST;
                            state_n = S_GAP;
                        end
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    idx_n = bit_idx - 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (gap_cnt == '0) begin
                    state_n = S_SEND;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rep_left <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            rep_left <= rep_n;
            bit_idx  <= idx_n;
            gap_cnt  <= gap_n;
        end
    end

    // Output registers, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            out   <= (state_n == S_SEND) ? PATTERN[idx_n] : 1'b0;
            valid <= (state_n == S_SEND);
            busy  <= (state_n != S_IDLE);
            done  <= (state_n == S_DONE);
        end
    end

endmodule
